// File: rtl/simplerisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simplerisc_pkg
// Description : Shared constants for the SimpleRISC core: register-file
//               geometry, named register indices and writeback requester ids.
// Revision    : 1.0 - initial release
// ============================================================================
package simplerisc_pkg;

    // Register file geometry
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;

    // Named registers
    localparam int REG_SP = 14;
    localparam int REG_RA = 15;

    // Writeback requester slots
    localparam int REQ_ALU  = 0;
    localparam int REQ_LSU  = 1;
    localparam int REQ_CALL = 2;

endpackage : simplerisc_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback request bus. The requesters (master) drive the
//               freeze, valid, address and data lanes; the arbiter (slave)
//               returns the one-hot ready vector.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 4,
    parameter int DW      = 32
);

    logic                  wb_hold;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;

    modport master (
        output wb_hold,
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  wb_hold,
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface : regfile_wb_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Picks the first asserted
//               valid bit searching upward from ptr, modulo NUM_REQ. Pointer
//               storage is left to the caller so the block can be reused for
//               other shared ports (e.g. the memory port).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 3
) (
    input  wire logic [NUM_REQ-1:0] valid,
    input  wire logic [PTR_W-1:0]   ptr,
    output logic      [NUM_REQ-1:0] grant,
    output logic      [PTR_W-1:0]   grant_idx,
    output logic                    grant_vld
);

    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    int w_dist;
    int w_best;

    // Each requester's priority is its distance above ptr; the smallest wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_dist    = 0;
        w_best    = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - (int'(ptr) % NUM_REQ)) % NUM_REQ;
            if (valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                grant_idx = PTR_W'(i);
                grant_vld = 1'b1;
            end
        end
        if (grant_vld) begin
            grant = c_ONE << grant_idx;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port between NUM_REQ
//               writeback requesters (ALU, load unit, call unit). A
//               round-robin grant is issued combinationally, the winner is
//               registered and written one cycle later. Also provides a
//               pending-write mask for hazard detection.
//               Optional macro WB_FWD_EN adds a write-cycle bypass for the
//               two read ports (fa1/fa2 -> fwd_hit1/fwd_hit2/fwd_data).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import simplerisc_pkg::*;
#(
    parameter int NUM_REQ = 3,            // 2..8
    parameter int AW      = REG_ADDR_W,
    parameter int DW      = REG_DATA_W
) (
    input  wire logic               Clk,
    input  wire logic               Reset,
    regfile_wb_arbiter_if.slave     bus,
    output logic                    IsWb,
    output logic [AW-1:0]           a3,
    output logic [DW-1:0]           d3,
    output logic [NUM_REGS-1:0]     pend_mask,
    output logic [2:0]              rr_ptr_o
`ifdef WB_FWD_EN
    ,
    input  wire logic [AW-1:0]      fa1,
    input  wire logic [AW-1:0]      fa2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [DW-1:0]           fwd_data
`endif
);

    localparam int                  c_PTR_W    = 3;
    localparam logic [NUM_REGS-1:0] c_REG_ONE  = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] w_valid_eff;
    logic [NUM_REQ-1:0] w_grant;
    logic [c_PTR_W-1:0] w_gidx;
    logic               w_gvld;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic [AW-1:0]      w_sel_addr;
    logic [DW-1:0]      w_sel_data;
    logic [NUM_REGS-1:0] w_pend;

    logic [c_PTR_W-1:0] r_ptr;
    logic               r_iswb;
    logic [AW-1:0]      r_a3;
    logic [DW-1:0]      r_d3;

    // Reset and pipeline freeze both suppress grants; pending requests
    // simply stay valid and compete once the block is released.
    assign w_valid_eff = (Reset || bus.wb_hold) ? '0 : bus.req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_rr_arbiter (
        .valid     (w_valid_eff),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_vld (w_gvld)
    );

    assign bus.req_ready = w_grant;

    assign w_ptr_next = (int'(w_gidx) == NUM_REQ - 1) ? '0 : (w_gidx + 1'b1);

    // One-hot grant selects the winning address/data lane
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | bus.req_addr[i*AW +: AW];
                w_sel_data = w_sel_data | bus.req_data[i*DW +: DW];
            end
        end
    end

    // Register the winner for next cycle's write; a3/d3 hold when idle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr  <= '0;
            r_iswb <= 1'b0;
            r_a3   <= '0;
            r_d3   <= '0;
        end else begin
            r_iswb <= w_gvld;
            if (w_gvld) begin
                r_ptr <= w_ptr_next;
                r_a3  <= w_sel_addr;
                r_d3  <= w_sel_data;
            end
        end
    end

    // Registers with a request in flight or a write landing this cycle
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                w_pend = w_pend | (c_REG_ONE << bus.req_addr[i*AW +: AW]);
            end
        end
        if (r_iswb) begin
            w_pend = w_pend | (c_REG_ONE << r_a3);
        end
    end

    assign IsWb      = r_iswb;
    assign a3        = r_a3;
    assign d3        = r_d3;
    assign pend_mask = w_pend;
    assign rr_ptr_o  = r_ptr;

`ifdef WB_FWD_EN
    // Reads sample while Clk is low, before the posedge write lands, so a
    // matching read address must take the in-flight data directly.
    assign fwd_hit1 = r_iswb && (fa1 == r_a3);
    assign fwd_hit2 = r_iswb && (fa2 == r_a3);
    assign fwd_data = r_d3;
`endif

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. A reference model
//               of the round-robin rules predicts grants and pushes expected
//               writes into a scoreboard queue; a monitor pops them whenever
//               the write port fires. Directed scenarios are followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          IsWb;
    logic [AW-1:0] a3;
    logic [DW-1:0] d3;
    logic [15:0]   pend_mask;
    logic [2:0]    rr_ptr_o;
`ifdef WB_FWD_EN
    logic [AW-1:0] fa1, fa2;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data;
`endif

    regfile_wb_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .IsWb      (IsWb),
        .a3        (a3),
        .d3        (d3),
        .pend_mask (pend_mask),
        .rr_ptr_o  (rr_ptr_o)
`ifdef WB_FWD_EN
        ,
        .fa1       (fa1),
        .fa2       (fa2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int            tag;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t q[$];

    // reference model state
    int            m_ptr  = 0;
    logic          m_iswb = 1'b0;
    logic [AW-1:0] m_a3   = '0;
    logic [DW-1:0] m_d3   = '0;
    int            m_g;
    logic [N-1:0]  m_rdy;
    logic [15:0]   m_pm;
    wr_t           m_e;

    // Reference model: predicts ready, pointer, pend mask and the write stage
    always @(negedge Clk) begin
        m_g = -1;
        if (Reset === 1'b0 && bus.wb_hold === 1'b0) begin
            for (int k = 0; k < N; k++) begin
                if (m_g < 0 && bus.req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
            end
        end
        m_rdy = (m_g >= 0) ? (N'(1) << m_g) : '0;
        m_pm  = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i]) m_pm[bus.req_addr[i*AW +: AW]] = 1'b1;
        end
        if (m_iswb) m_pm[m_a3] = 1'b1;

        chk("req_ready", 64'(bus.req_ready), 64'(m_rdy));
        chk("rr_ptr",    64'(rr_ptr_o),      64'(m_ptr));
        chk("pend_mask", 64'(pend_mask),     64'(m_pm));
        chk("IsWb",      64'(IsWb),          64'(m_iswb));
`ifdef WB_FWD_EN
        chk("fwd_hit1", 64'(fwd_hit1), 64'(m_iswb && (fa1 == m_a3)));
        chk("fwd_hit2", 64'(fwd_hit2), 64'(m_iswb && (fa2 == m_a3)));
        chk("fwd_data", 64'(fwd_data), 64'(m_d3));
`endif

        if (Reset === 1'b1) begin
            m_ptr = 0; m_iswb = 1'b0; m_a3 = '0; m_d3 = '0;
        end else if (m_g >= 0) begin
            m_e.tag = cyc;
            m_e.a   = bus.req_addr[m_g*AW +: AW];
            m_e.d   = bus.req_data[m_g*DW +: DW];
            q.push_back(m_e);
            m_iswb = 1'b1; m_a3 = m_e.a; m_d3 = m_e.d;
            m_ptr  = (m_g + 1) % N;
        end else begin
            m_iswb = 1'b0;
        end
    end

    // shadow register file built from observed writes
    logic [DW-1:0] rf [16];
    wr_t           mon_e;

    // Monitor: every write on the port must match the oldest expected entry
    always @(negedge Clk) begin
        if (IsWb === 1'b1) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb_unexpected: got write a3=%0h d3=%0h expected no write (cycle %0d)", a3, d3, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("wb_latency", 64'(cyc), 64'(mon_e.tag + 1));
                chk("wb_a3",      64'(a3),  64'(mon_e.a));
                chk("wb_d3",      64'(d3),  64'(mon_e.d));
            end
            rf[a3] = d3;
        end else if (q.size() > 0 && q[0].tag < cyc) begin
            mon_e = q.pop_front();
            checks++; errors++;
            $display("FAIL wb_missing: got IsWb=%0b expected write a3=%0h d3=%0h (cycle %0d)", IsWb, mon_e.a, mon_e.d, cyc);
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0]  p_valid;
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_data [N];
    logic          p_hold;
    logic [N-1:0]  t_fire;

    task automatic drive();
        bus.wb_hold = p_hold;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = p_valid[i];
            bus.req_addr[i*AW +: AW]  = p_addr[i];
            bus.req_data[i*DW +: DW]  = p_data[i];
        end
    endtask

    // One cycle: note handshakes, step past the edge, retire completed requests
    task automatic tick();
        @(negedge Clk);
        #1;
        t_fire = bus.req_valid & bus.req_ready;
        @(posedge Clk);
        #1;
        p_valid = p_valid & ~t_fire;
    endtask

    task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p_valid[i]) begin
            p_valid[i] = 1'b1;
            p_addr[i]  = a;
            p_data[i]  = d;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = '0;
        Reset   = 1'b1;
        p_hold  = 1'b0;
        p_valid = '0;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = AW'(i + 1);
            p_data[i] = 32'h1000 + DW'(i);
        end
`ifdef WB_FWD_EN
        fa1 = 4'd7;
        fa2 = 4'd3;
`endif

        // Reset with all requests raised: nothing accepted, all stay pending
        p_valid = 3'b111;
        run(2);
        Reset = 1'b0;

        // All three continuously valid: grants 0,1,2,0
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) post(i, AW'(i + 1), 32'h2000 + DW'(k * 8 + i));
            run(1);
        end
        p_valid = '0;
        run(2);

        // Single ALU request
        post(0, 4'd5, 32'hDEADBEEF);
        run(3);

        // Write registered just before a 3-cycle hold, requester 1 waiting
        post(0, 4'd7, 32'h0000_0777);
        run(1);
        p_hold = 1'b1;
        post(1, 4'd9, 32'h0000_0999);
        run(3);
        p_hold = 1'b0;
        run(3);

        // Bring pointer to 2, then requesters 0 and 2 both write r14
        post(1, 4'd4, 32'h0000_0444);
        run(1);
        post(0, 4'd14, 32'h0000_0100);
        post(2, 4'd14, 32'h0000_0200);
        run(3);
        chk("r14_final", 64'(rf[14]), 64'h100);

        // Randomized traffic with holds and occasional resets
        for (int k = 0; k < 400; k++) begin
            p_hold = ($urandom_range(0, 99) < 20);
            Reset  = ($urandom_range(0, 99) < 3);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 50) post(i, AW'($urandom), $urandom);
            end
`ifdef WB_FWD_EN
            fa1 = AW'($urandom);
            fa2 = AW'($urandom);
`endif
            run(1);
        end
        Reset   = 1'b0;
        p_hold  = 1'b0;
        p_valid = '0;
        run(4);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (IsWb/a3/d3) between NUM_REQ writeback requesters, e.g. 0=ALU, 1=load unit, 2=call unit writing r15.
- Each requester uses a valid/ready handshake.
- A round-robin arbiter grants at most one request per cycle.
- The winning request is registered and driven to the register file on the following cycle.
- Also exports a 16-bit pending-write mask for the hazard/stall logic.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
AW, 4, register address width (16 registers)
DW, 32, register data width

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
wb_hold  input  1  pipeline freeze; when 1 no grant is issued
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*AW  packed destination register, requester i at [i*AW +: AW]
req_data  input  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
IsWb  output  1  register-file write enable (registered)
a3  output  AW  register-file write address (registered)
d3  output  DW  register-file write data (registered)
pend_mask  output  16  bit r set if register r has a valid request or is being written this cycle
rr_ptr_o  output  3  current round-robin pointer (debug/verification)

Behaviour:
- Reset (sampled at posedge Clk):
  - IsWb=0, a3=0, d3=0, rr_ptr=0.
  - Reset overrides all other inputs in the same cycle.
  - req_ready is forced to 0 while Reset=1.
  - A request presented during reset is not accepted; it stays pending and is eligible after reset deasserts.
- Arbitration (combinational):
  - If wb_hold=0 and Reset=0, search from rr_ptr ascending modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - At most one ready bit is ever set.
- Pointer update:
  - On a grant to k, rr_ptr <= (k+1) mod NUM_REQ.
  - With no grant (no valid request, or wb_hold=1), rr_ptr holds.
  - Wrap: a grant to NUM_REQ-1 sets rr_ptr=0.
- Output stage, latency 1 cycle from handshake to IsWb:
  - On a grant: IsWb<=1, a3<=req_addr[k], d3<=req_data[k].
  - Otherwise IsWb<=0, and a3/d3 hold their previous values.
  - Back-to-back grants give continuous IsWb=1 at one write per cycle.
- wb_hold:
  - Blocks new grants only.
  - A write already registered still completes: IsWb stays 1 for that cycle, then drops.
- Requester contract:
  - Once valid is raised, addr and data stay stable until ready.
  - Ready never depends on a request being withdrawn.
- pend_mask = OR over i of (req_valid[i] ? onehot(req_addr[i]) : 0), OR (IsWb ? onehot(a3) : 0). It is combinational.
- Same-address requests in one cycle:
  - Write order follows arbitration order; the later grant wins the final register value.
  - No merging or dropping.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles of wb_hold=0.

Optional Feature:
Macro WB_FWD_EN.
- Defined: adds inputs fa1[AW] and fa2[AW], and outputs fwd_hit1, fwd_hit2 and fwd_data[DW].
  - fwd_hitN = IsWb & (faN==a3); fwd_data = d3.
  - These let the read stage bypass the register file during the write cycle, since reads are sampled while Clk is low, before the posedge write lands.
- Undefined: these ports and the logic do not exist; the port list is otherwise identical.

Decomposition:
- Shared package simplerisc_pkg holds:
  - REG_ADDR_W=4, REG_DATA_W=32, NUM_REGS=16
  - register index constants REG_SP=14, REG_RA=15
  - requester index constants REQ_ALU=0, REQ_LSU=1, REQ_CALL=2
- One sub-module: rr_arbiter (parameterised NUM_REQ; inputs valid and ptr; outputs one-hot grant and grant index). It is reusable for the memory-port arbiter.

Test Plan:
- Reset=1 for 2 cycles with req_valid=3'b111 -> req_ready=0, IsWb=0, rr_ptr_o=0; after release, first grant goes to requester 0.
- Single request, ALU: addr=5, data=32'hDEADBEEF -> req_ready[0]=1 the same cycle; next cycle IsWb=1, a3=5, d3=DEADBEEF; the following cycle IsWb=0.
- All three valid continuously with addrs 1/2/3 -> grants 0,1,2,0 on consecutive cycles; IsWb stays 1; rr_ptr_o sequence 1,2,0,1.
- wb_hold=1 for 3 cycles with requester 1 valid -> no ready and rr_ptr unchanged; a write registered the cycle before hold still completes; grant issues the cycle after hold drops.
- Requesters 0 and 2 both target r14 (data 0x100 and 0x200), rr_ptr=2 -> write 0x200 then 0x100; pend_mask[14]=1 until the second write's IsWb cycle ends.
- With WB_FWD_EN: IsWb=1, a3=7, fa1=7, fa2=3 -> fwd_hit1=1, fwd_hit2=0, fwd_data=d3.
